// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared sizes and ALU opcode encodings
package reservation_station_pkg;
  localparam int ROB_SIZE_BIT = 5;
  localparam int RS_SIZE = 8;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_EQ, OP_NE, OP_LT, OP_GE, OP_LTU, OP_GEU
  } alu_op_e;
endpackage

// File: rtl/reservation_station_alu.sv
// alu: combinational 16-op integer datapath; compares return 0 or 1
module alu
  import reservation_station_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);
  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      OP_SRA:  result = $signed(a) >>> b[4:0];
      OP_SLT:  result = {31'b0, $signed(a) < $signed(b)};
      OP_SLTU: result = {31'b0, a < b};
      OP_EQ:   result = {31'b0, a == b};
      OP_NE:   result = {31'b0, a != b};
      OP_LT:   result = {31'b0, $signed(a) < $signed(b)};
      OP_GE:   result = {31'b0, $signed(a) >= $signed(b)};
      OP_LTU:  result = {31'b0, a < b};
      OP_GEU:  result = {31'b0, a >= b};
    endcase
  end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: tag-matching issue queue with lowest-index select and
// a registered ALU result broadcast that also wakes its own entries.
module reservation_station #(
  parameter int RS_SIZE = reservation_station_pkg::RS_SIZE,
  parameter int ROB_SIZE_BIT = reservation_station_pkg::ROB_SIZE_BIT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    rob_clear,
  input  logic                    issue_valid,
  input  logic [3:0]              issue_op,
  input  logic [ROB_SIZE_BIT-1:0] issue_rob_id,
  input  logic [31:0]             issue_v1,
  input  logic [31:0]             issue_v2,
  input  logic                    issue_q1_pend,
  input  logic                    issue_q2_pend,
  input  logic [ROB_SIZE_BIT-1:0] issue_q1,
  input  logic [ROB_SIZE_BIT-1:0] issue_q2,
  output logic                    rs_full,
  input  logic                    lsb_fi,
  input  logic [31:0]             lsb_value,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
  output logic                    rs_fi,
  output logic [31:0]             rs_value,
  output logic [ROB_SIZE_BIT-1:0] rs_rob_id
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy, q1_pend, q2_pend;
  logic [3:0] op [RS_SIZE];
  logic [ROB_SIZE_BIT-1:0] rob_id [RS_SIZE], q1 [RS_SIZE], q2 [RS_SIZE];
  logic [31:0] v1 [RS_SIZE], v2 [RS_SIZE];
  logic [IW-1:0] free_idx, sel_idx;
  logic has_sel;
  logic [31:0] alu_res;
  assign rs_full = &busy;
  always_comb begin
    free_idx = '0;
    sel_idx = '0;
    has_sel = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      free_idx = busy[i] ? free_idx : IW'(i);
      if (busy[i] && !q1_pend[i] && !q2_pend[i]) begin
        has_sel = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end
  alu u_alu (.op(op[sel_idx]), .a(v1[sel_idx]), .b(v2[sel_idx]), .result(alu_res));
  // {still_pending, value}; the own ALU broadcast takes precedence over the LSB
  function automatic logic [32:0] fwd(input logic pend, input logic [ROB_SIZE_BIT-1:0] q,
                                      input logic [31:0] v);
    return !pend ? {1'b0, v} :
           (rs_fi && rs_rob_id == q) ? {1'b0, rs_value} :
           (lsb_fi && lsb_rob_id == q) ? {1'b0, lsb_value} : {1'b1, v};
  endfunction
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy <= '0;
      rs_fi <= 1'b0;
      rs_value <= '0;
      rs_rob_id <= '0;
    end else if (rdy_in && rob_clear) begin
      busy <= '0;
      rs_fi <= 1'b0;
    end else if (rdy_in) begin
      rs_fi <= has_sel;
      for (int i = 0; i < RS_SIZE; i++)
        if (busy[i]) begin
          {q1_pend[i], v1[i]} <= fwd(q1_pend[i], q1[i], v1[i]);
          {q2_pend[i], v2[i]} <= fwd(q2_pend[i], q2[i], v2[i]);
        end
      if (has_sel) begin
        busy[sel_idx] <= 1'b0;
        rs_value <= alu_res;
        rs_rob_id <= rob_id[sel_idx];
      end
      if (issue_valid && !rs_full) begin
        busy[free_idx] <= 1'b1;
        op[free_idx] <= issue_op;
        rob_id[free_idx] <= issue_rob_id;
        q1[free_idx] <= issue_q1;
        q2[free_idx] <= issue_q2;
        {q1_pend[free_idx], v1[free_idx]} <= fwd(issue_q1_pend, issue_q1, issue_v1);
        {q2_pend[free_idx], v2[free_idx]} <= fwd(issue_q2_pend, issue_q2, issue_v2);
      end
    end
  end
endmodule
